// File: rtl/imem_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction RAM.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the core is released.
//
// state | meaning
// HDR0  | waiting for word-count low byte
// HDR1  | waiting for word-count high byte
// DATA  | receiving payload bytes, one RAM write per 4 bytes
// CSUM  | waiting for checksum byte (LOADER_CHECKSUM_EN only)
// DONE  | image loaded, core released
// ERR   | load aborted, core held in reset
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ByteValid,
  input  logic [7:0]  ByteData,
  output logic        ByteReady,
  output logic        ImemWE,
  output logic [31:0] ImemAdr,
  output logic [31:0] ImemWD,
  output logic        CpuReset,
  output logic        Done,
  output logic        Error
);

  localparam int          IW      = $clog2(DEPTH + 1);
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
`ifdef LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t TAIL = CSUM;
`else
  localparam state_t TAIL = DONE;
`endif

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [1:0]      lane_q, lane_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   idx_nxt;
  logic [31:0]     idx_ext;
  logic [23:0]     asm_q, asm_d;
  logic            we_q, we_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     wd_q, wd_d;
  logic            accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      xor_q, xor_d;
`endif

  assign ByteReady = (state_q != DONE) && (state_q != ERR);
  assign accept    = ByteValid & ByteReady;
  assign idx_nxt   = idx_q + 1'b1;
  assign idx_ext   = 32'(idx_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    adr_d   = adr_q;
    wd_d    = wd_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    if (accept) begin
`ifdef LOADER_CHECKSUM_EN
      xor_d = xor_q ^ ByteData;
`endif
      case (state_q)
        HDR0: begin
          cnt_d[7:0] = ByteData;
          state_d    = HDR1;
        end
        HDR1: begin
          cnt_d[15:8] = ByteData;
          if ({1'b0, ByteData, cnt_q[7:0]} > DEPTH_W)
            state_d = ERR;
          else if ({ByteData, cnt_q[7:0]} == 16'd0)
            state_d = TAIL;
          else
            state_d = DATA;
        end
        DATA: begin
          // Bytes enter at the top so the first byte ends up least significant.
          lane_d = lane_q + 2'd1;
          asm_d  = {ByteData, asm_q[23:8]};
          if (lane_q == 2'd3) begin
            we_d  = 1'b1;
            wd_d  = {ByteData, asm_q};
            adr_d = {idx_ext[29:0], 2'b00};
            idx_d = idx_nxt;
            if (17'(idx_nxt) == {1'b0, cnt_q})
              state_d = TAIL;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          state_d = (ByteData == xor_q) ? DONE : ERR;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HDR0;
      cnt_q   <= '0;
      lane_q  <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wd_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign ImemWE   = we_q;
  assign ImemAdr  = adr_q;
  assign ImemWD   = wd_q;
  assign CpuReset = (state_q != DONE);
  assign Done     = (state_q == DONE);
  assign Error    = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed vector table, mid-stream reset sequence and randomized streams
// checked against a stream-level reference model.
module tb_imem_loader;
  localparam int DEPTH = 64;
`ifdef LOADER_CHECKSUM_EN
  localparam int CSUM_EN = 1;
`else
  localparam int CSUM_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ByteValid = 1'b0;
  logic [7:0]  ByteData = 8'h00;
  logic        ByteReady, ImemWE, CpuReset, Done, Error;
  logic [31:0] ImemAdr, ImemWD;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ByteValid(ByteValid), .ByteData(ByteData),
    .ByteReady(ByteReady), .ImemWE(ImemWE), .ImemAdr(ImemAdr), .ImemWD(ImemWD),
    .CpuReset(CpuReset), .Done(Done), .Error(Error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [63:0] got_q[$];
  int          got_cyc[$];

  always @(posedge clk) cyc++;
  always @(negedge clk) if (ImemWE) begin
    got_q.push_back({ImemAdr, ImemWD});
    got_cyc.push_back(cyc);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, ByteReady, 1);
    chk({tag, "_we"}, ImemWE, 0);
    chk({tag, "_adr"}, ImemAdr, 0);
    chk({tag, "_wd"}, ImemWD, 0);
    chk({tag, "_cpurst"}, CpuReset, 1);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_err"}, Error, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ByteValid = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      ByteValid = 1'b0;
      ByteData  = 8'($urandom);
    end
    @(negedge clk);
    ByteValid = 1'b1;
    ByteData  = b;
    for (int t = 0; t < 50 && !ByteReady; t++) @(negedge clk);
    chk("byte_ready", ByteReady, 1);
    if (ByteReady) @(posedge clk);
  endtask

  // Reference: parse the stream by its rules and list the writes and final outcome.
  task automatic model(input logic [7:0] s[$], output logic [63:0] exp[$], output int nacc,
                       output bit e_done, output bit e_err, output int n);
    logic [7:0] x;
    exp.delete();
    n = int'(s[0]) + 256 * int'(s[1]);
    if (n > DEPTH) begin
      nacc = 2; e_done = 0; e_err = 1;
      return;
    end
    for (int i = 0; i < n; i++)
      exp.push_back({32'(i * 4), s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]});
    nacc = 2 + 4 * n;
    e_done = 1; e_err = 0;
    if (CSUM_EN != 0) begin
      x = 8'h00;
      for (int i = 0; i < nacc; i++) x ^= s[i];
      if (s[nacc] != x) begin e_done = 0; e_err = 1; end
      nacc++;
    end
  endtask

  task automatic run(input logic [7:0] s[$], input int stall, output int nwr);
    logic [63:0] exp[$];
    int nacc, n;
    bit e_done, e_err, e_we_last;
    model(s, exp, nacc, e_done, e_err, n);
    do_reset();
    got_q.delete();
    got_cyc.delete();
    for (int i = 0; i < nacc; i++)
      send_byte(s[i], (stall < 0) ? int'($urandom_range(0, 3)) : stall);
    @(negedge clk);
    ByteValid = 1'b0;
    e_we_last = (CSUM_EN == 0) && e_done && (n > 0);
    chk("end_done", Done, e_done);
    chk("end_error", Error, e_err);
    chk("end_cpu_reset", CpuReset, !e_done);
    chk("end_byte_ready", ByteReady, 0);
    chk("end_we_last", ImemWE, e_we_last);
    ByteValid = 1'b1;
    ByteData  = 8'($urandom);
    repeat (4) @(negedge clk);
    ByteValid = 1'b0;
    @(negedge clk);
    chk("hold_done", Done, e_done);
    chk("hold_error", Error, e_err);
    chk("nwrites", got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      chk("write", got_q[i], exp[i]);
    if (exp.size() > 0) chk("adr_wd_hold", {ImemAdr, ImemWD}, exp[exp.size()-1]);
    nwr = got_q.size();
  endtask

  typedef struct {
    logic [95:0] b;
    int          len;
    int          stall;
    bit          exp_done;
    bit          exp_err;
    int          exp_nwr;
    logic [31:0] wd0;
    logic [31:0] wd1;
    bit          spacing;
  } vec_t;

  vec_t tab[5];

  initial begin
    logic [7:0]  s[$];
    logic [95:0] good, bad;
    int ntab, nwr, n;
    bit corrupt;
    logic [7:0] x;

    good = {8'h00, 88'hE5E2802005E04F000F0002};
    bad  = {8'h00, 88'hE4E2802005E04F000F0002};
    tab[0] = '{good, 10 + CSUM_EN, 0, 1, 0, 2, 32'hE04F000F, 32'hE2802005, 1};
    tab[1] = '{good, 10 + CSUM_EN, 3, 1, 0, 2, 32'hE04F000F, 32'hE2802005, 0};
    tab[2] = '{96'h0041, 2, 0, 0, 1, 0, 32'h0, 32'h0, 0};
    tab[3] = '{96'h0, 2 + CSUM_EN, 1, 1, 0, 0, 32'h0, 32'h0, 0};
    tab[4] = '{bad, 11, 0, 0, 1, 2, 32'hE04F000F, 32'hE2802005, 0};
    ntab = 4 + CSUM_EN;

    for (int i = 0; i < ntab; i++) begin
      s.delete();
      for (int j = 0; j < tab[i].len; j++) s.push_back(tab[i].b[8*j +: 8]);
      run(s, tab[i].stall, nwr);
      chk("tab_nwr", nwr, tab[i].exp_nwr);
      chk("tab_done", Done, tab[i].exp_done);
      chk("tab_err", Error, tab[i].exp_err);
      if (tab[i].exp_nwr >= 2) begin
        chk("tab_w0", got_q[0], {32'h0, tab[i].wd0});
        chk("tab_w1", got_q[1], {32'h4, tab[i].wd1});
      end
      if (tab[i].spacing) chk("tab_we_spacing", got_cyc[1] - got_cyc[0], 4);
    end

    // Reset partway through the payload, then a full clean load.
    do_reset();
    for (int j = 0; j < 8; j++) send_byte(good[8*j +: 8], 0);
    @(negedge clk);
    ByteValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    s.delete();
    for (int j = 0; j < 10 + CSUM_EN; j++) s.push_back(good[8*j +: 8]);
    run(s, 0, nwr);
    chk("midrst_nwr", nwr, 2);
    chk("midrst_w0", got_q[0], {32'h0, 32'hE04F000F});
    chk("midrst_done", Done, 1);

    for (int it = 0; it < 25; it++) begin
      s.delete();
      case ($urandom_range(0, 9))
        0: n = $urandom_range(DEPTH + 1, 300);
        1: n = DEPTH;
        default: n = $urandom_range(0, 5);
      endcase
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      if (n > DEPTH) begin
        s.push_back(8'($urandom));
      end else begin
        for (int k = 0; k < 4 * n; k++) s.push_back(8'($urandom));
        x = 8'h00;
        foreach (s[k]) x ^= s[k];
        corrupt = ($urandom_range(0, 3) == 0);
        s.push_back(corrupt ? (x ^ (8'h01 << $urandom_range(0, 7))) : x);
      end
      run(s, -1, nwr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the single-cycle ARM core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into a writable instruction RAM through a one-word write port. The core is held in reset until a complete image has been loaded (and, optionally, checksum-verified).

## Interface
Parameters:
- DEPTH, 64: instruction RAM size in words; legal range 1..65535.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; returns the block to HDR0.
- ByteValid  in  1  upstream has a byte on ByteData.
- ByteData  in  8  stream byte.
- ByteReady  out  1  block can accept a byte this cycle.
- ImemWE  out  1  one-cycle write strobe to instruction RAM.
- ImemAdr  out  32  byte address of the word being written (word index << 2).
- ImemWD  out  32  instruction word being written.
- CpuReset  out  1  reset to the ARM core; high until load completes.
- Done  out  1  image loaded successfully.
- Error  out  1  load aborted.

## Operation
- A byte is accepted on a rising edge where ByteValid & ByteReady. ByteData is ignored otherwise.
- Stream format: count low byte, count high byte (N = 16-bit word count), then 4·N payload bytes (each word least-significant byte first), then an optional checksum byte (see Configuration).
- States: HDR0 -> HDR1 -> DATA -> [CSUM] -> DONE. Any state may go to ERR as listed below.
  - HDR0: on accept, latch count[7:0]; go to HDR1.
  - HDR1: on accept, latch count[15:8]. If N > DEPTH, go to ERR. If N == 0, go to CSUM (macro defined) or DONE. Otherwise go to DATA.
  - DATA: shift the byte into the word assembler and increment the byte lane (0..3). On lane 3, issue a write and increment the word index. When word index reaches N, go to CSUM or DONE.
  - CSUM: on accept, compare the byte with the running XOR. Equal -> DONE; unequal -> ERR.
  - DONE / ERR: terminal. Both are left only through reset.
- ByteReady = 1 in HDR0, HDR1, DATA and CSUM; 0 in DONE and ERR.
- CpuReset = 1 in every state except DONE. Done = (state == DONE). Error = (state == ERR).
- Word index width is $clog2(DEPTH+1). ImemAdr = {index, 2'b00}, zero-extended to 32 bits.
- Bytes presented while ByteValid = 0 have no effect. Stalls of any length between bytes are legal.

## Timing
- Reset values: state HDR0, ByteReady 1, ImemWE 0, ImemAdr 0, ImemWD 0, CpuReset 1, Done 0, Error 0. Counters and the XOR accumulator are cleared.
- ImemWE, ImemAdr and ImemWD are registered. ImemWE is high for exactly the one cycle after the edge that accepts the 4th byte of a word. ImemAdr/ImemWD hold their values until the next write.
- Back-to-back words at one byte per cycle produce one ImemWE pulse every 4 cycles.
- Done/CpuReset change on the same edge the state enters DONE, which is the edge accepting the last byte. If the last byte is a payload byte, the final ImemWE pulse occurs in the same cycle CpuReset falls. Instruction RAM writes complete on that edge, before the core's first fetch.
- An assertion of reset mid-stream aborts the load immediately. The partial image in RAM is not cleared; the next stream restarts at word 0.

## Configuration
- LOADER_CHECKSUM_EN defined: CSUM state present. The stream ends with one byte equal to the XOR of every preceding byte, including both header bytes. A mismatch goes to ERR and the core stays in reset.
- Not defined: the CSUM state and XOR accumulator are omitted. The state after the last payload byte (or after HDR1 when N = 0) is DONE. A byte following the image is not accepted (ByteReady = 0).

## Test plan
- Stream 02 00 0F 00 4F E0 05 20 80 E2 [E5] at one byte/cycle -> ImemWE pulses with (0x0, 0xE04F000F) and (0x4, 0xE2802005). Then Done = 1, CpuReset = 0, ByteReady = 0.
- Same stream with ByteValid deasserted for 3 cycles between every byte -> identical writes and final state; no extra ImemWE pulses.
- (LOADER_CHECKSUM_EN) Same stream with final byte E4 -> both writes occur, then Error = 1, Done = 0, CpuReset = 1.
- Header 41 00 with DEPTH = 64 -> Error = 1 after the second byte; no ImemWE ever.
- Header 00 00 [00] -> Done = 1 with zero writes.
- Assert reset after 6 payload bytes, then send the full valid stream -> exactly two writes to 0x0 and 0x4 after reset, then Done = 1.
